// File: rtl/bshift_reg.sv
// Handshaked shift/rotate register: one-bit-per-cycle iterative datapath by default,
// single-cycle barrel datapath when BSHIFT_FAST_EN is defined.
module bshift_reg #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [1:0]       MODE,
   input  logic [SHW-1:0]   AMT,
   input  logic [WIDTH-1:0] DIN,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] DOUT
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [1:0]       mode_q, mode_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q, in_ready_d;

   function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] d, input logic [1:0] m);
      case (m)
         2'b00:   step1 = {d[WIDTH-2:0], d[WIDTH-1]};
         2'b01:   step1 = {d[0], d[WIDTH-1:1]};
         2'b10:   step1 = {d[WIDTH-2:0], 1'b0};
         2'b11:   step1 = {1'b0, d[WIDTH-1:1]};
         default: step1 = d;
      endcase
   endfunction

   // Barrel stage built from the same one-bit step so both builds agree bit-for-bit.
   function automatic logic [WIDTH-1:0] barrel(input logic [WIDTH-1:0] d, input logic [1:0] m,
                                               input logic [SHW-1:0] a);
      logic [WIDTH-1:0] r;
      r = d;
      for (int i = 0; i < WIDTH - 1; i++) begin
         if (SHW'(i) < a) begin
            r = step1(r, m);
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   // Next-state, datapath and handshake flag computation.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      case (state_q)
         ST_IDLE: begin
            if (IN_VALID) begin
               mode_d = MODE;
               data_d = DIN;
`ifdef BSHIFT_FAST_EN
               cnt_d   = {SHW{1'b0}};
               dout_d  = barrel(DIN, MODE, AMT);
               state_d = ST_DONE;
`else
               cnt_d = AMT;
               if (AMT == {SHW{1'b0}}) begin
                  dout_d  = DIN;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SHIFT;
               end
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            // DOUT only picks up the final step, never an intermediate value.
            data_d = step1(data_q, mode_q);
            cnt_d  = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               dout_d  = step1(data_q, mode_q);
               state_d = ST_DONE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_DONE: begin
            if (OUT_READY) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      out_valid_d = (state_d == ST_DONE);
      in_ready_d  = (state_d == ST_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         data_q      <= {WIDTH{1'b0}};
         mode_q      <= 2'b00;
         cnt_q       <= {SHW{1'b0}};
         dout_q      <= {WIDTH{1'b0}};
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         mode_q      <= mode_d;
         cnt_q       <= cnt_d;
         dout_q      <= dout_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign DOUT      = dout_q;
   assign OUT_VALID = out_valid_q;
   assign IN_READY  = in_ready_q;

endmodule

// File: tb/tb_bshift_reg.sv
// Directed self-checking bench for bshift_reg (WIDTH=8); expected latency follows BSHIFT_FAST_EN.
module tb_bshift_reg;

`ifdef BSHIFT_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       IN_VALID = 1'b0;
   logic       IN_READY;
   logic [1:0] MODE = 2'b00;
   logic [2:0] AMT = 3'd0;
   logic [7:0] DIN = 8'h00;
   logic       OUT_VALID;
   logic       OUT_READY = 1'b0;
   logic [7:0] DOUT;

   int pass_cnt = 0;
   int total_cnt = 0;
   logic [7:0] dout_before;

   bshift_reg #(.WIDTH(8)) dut (
      .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .MODE(MODE), .AMT(AMT), .DIN(DIN), .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY), .DOUT(DOUT)
   );

   always #5 CLK = ~CLK;

   function automatic int exp_lat(input int amt);
      return FAST ? 1 : amt + 1;
   endfunction

   // Drive one request when IN_READY is seen, then scramble inputs to prove they are ignored.
   task automatic send(input logic [1:0] m, input logic [7:0] d, input logic [2:0] a);
      int w = 0;
      while (IN_READY !== 1'b1 && w < 40) begin
         @(posedge CLK); #1; w++;
      end
      dout_before = DOUT;
      MODE = m; DIN = d; AMT = a; IN_VALID = 1'b1;
      @(posedge CLK); #1;
      IN_VALID = 1'b0; MODE = ~m; DIN = 8'h3C; AMT = 3'd5;
   endtask

   task automatic wait_valid(output int lat, output bit unstable);
      lat = 1; unstable = 1'b0;
      while (OUT_VALID !== 1'b1 && lat < 40) begin
         if (DOUT !== dout_before) unstable = 1'b1;
         @(posedge CLK); #1; lat++;
      end
   endtask

   task automatic handoff();
      OUT_READY = 1'b1;
      @(posedge CLK); #1;
      OUT_READY = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      @(posedge CLK); #1;
      total_cnt++; if (DOUT !== 8'h00) $display("FAIL reset_dout: got %h expected 00", DOUT); else pass_cnt++;
      total_cnt++; if (OUT_VALID !== 1'b0) $display("FAIL reset_valid: got %b expected 0", OUT_VALID); else pass_cnt++;
      total_cnt++; if (IN_READY !== 1'b1) $display("FAIL reset_ready: got %b expected 1", IN_READY); else pass_cnt++;
   endtask

   task automatic test_vectors();
      logic [1:0] m   [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b01};
      logic [7:0] d   [5] = '{8'h81, 8'h81, 8'hF0, 8'hF0, 8'hA5};
      logic [2:0] a   [5] = '{3'd3, 3'd3, 3'd7, 3'd4, 3'd0};
      logic [7:0] exp [5] = '{8'h0C, 8'h30, 8'h01, 8'h00, 8'hA5};
      int lat; bit unstable;
      for (int i = 0; i < 5; i++) begin
         send(m[i], d[i], a[i]);
         wait_valid(lat, unstable);
         total_cnt++; if (lat != exp_lat(int'(a[i]))) $display("FAIL vec%0d_latency: got %0d expected %0d", i, lat, exp_lat(int'(a[i]))); else pass_cnt++;
         total_cnt++; if (DOUT !== exp[i]) $display("FAIL vec%0d_dout: got %h expected %h", i, DOUT, exp[i]); else pass_cnt++;
         total_cnt++; if (unstable) $display("FAIL vec%0d_no_intermediate: got changing DOUT expected stable %h", i, dout_before); else pass_cnt++;
         handoff();
         total_cnt++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) $display("FAIL vec%0d_handoff: got valid=%b ready=%b expected valid=0 ready=1", i, OUT_VALID, IN_READY); else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back_hold();
      int lat; bit unstable; bit bad;
      send(2'b00, 8'h81, 3'd3);
      wait_valid(lat, unstable);
      IN_VALID = 1'b1; DIN = 8'h55; MODE = 2'b11; AMT = 3'd1;
      bad = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge CLK); #1;
         if (DOUT !== 8'h0C || OUT_VALID !== 1'b1 || IN_READY !== 1'b0) bad = 1'b1;
      end
      total_cnt++; if (bad) $display("FAIL hold_stable: got dout=%h valid=%b ready=%b expected 0c 1 0", DOUT, OUT_VALID, IN_READY); else pass_cnt++;
      OUT_READY = 1'b1;
      @(posedge CLK); #1;
      OUT_READY = 1'b0;
      total_cnt++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || DOUT !== 8'h0C) $display("FAIL hold_release: got valid=%b ready=%b dout=%h expected 0 1 0c", OUT_VALID, IN_READY, DOUT); else pass_cnt++;
      dout_before = DOUT;
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      wait_valid(lat, unstable);
      total_cnt++; if (DOUT !== 8'h2A) $display("FAIL hold_next_dout: got %h expected 2a", DOUT); else pass_cnt++;
      total_cnt++; if (lat != exp_lat(1)) $display("FAIL hold_next_latency: got %0d expected %0d", lat, exp_lat(1)); else pass_cnt++;
      handoff();
   endtask

   task automatic test_reset_mid();
      int lat; bit unstable; bit seen;
      send(2'b00, 8'h81, 3'd6);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      total_cnt++; if (DOUT !== 8'h00 || IN_READY !== 1'b1 || OUT_VALID !== 1'b0) $display("FAIL midrst_state: got dout=%h ready=%b valid=%b expected 00 1 0", DOUT, IN_READY, OUT_VALID); else pass_cnt++;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (OUT_VALID !== 1'b0) seen = 1'b1;
         @(posedge CLK); #1;
      end
      total_cnt++; if (seen) $display("FAIL midrst_no_valid: got OUT_VALID=1 expected 0"); else pass_cnt++;
      send(2'b10, 8'h0F, 3'd2);
      wait_valid(lat, unstable);
      total_cnt++; if (DOUT !== 8'h3C) $display("FAIL midrst_recover: got %h expected 3c", DOUT); else pass_cnt++;
      handoff();
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_back_to_back_hold();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
